nabp_param_dual_port_ram: RTL and testbench
===========================================

// Module: nabp_param_dual_port_ram
// PURPOSE
// - Parametrised true dual-port RAM for projection-line / filtered-data buffering in the NABP datapath.
// - Successor of the simple dual-port RAM, adding:
//   - a synthesisable sequential clear sweep,
//   - per-port enables with a valid pipeline,
//   - selectable read latency and same-port read-during-write mode,
//   - write-collision detection.
// - Sits between the filter stage and the backprojection accumulators.
// PARAMETERS
// - pDataLength  = `kFilteredDataLength : word width in bits
// - pRAMSize     = `kProjectionLineSize : number of words
// - pAddrLength  = `kSLength            : address width, >= clog2(pRAMSize)
// - pReadLatency = 1 : 1 or 2 cycles from enable to data_out_x (2 adds an output register)
// - pWriteMode   = 0 : same-port read-during-write; 0 = write-first, 1 = read-first
// PORTS
// - clk           in   1    : single clock, all logic on posedge
// - reset_n       in   1    : asynchronous active-low reset
// - clear         in   1    : synchronous request to zero all contents (one-cycle pulse)
// - clear_busy    out  1    : high while the clear sweep runs
// - collision     out  1    : one-cycle pulse, both ports wrote the same address
// - en_x          in   1    : port x access enable (x = 0, 1)
// - we_x          in   1    : port x write enable, qualified by en_x
// - addr_x        in   pAddrLength : port x address
// - data_in_x     in   pDataLength : port x write data
// - data_out_x    out  pDataLength : port x read data
// - valid_x       out  1    : data_out_x updated this cycle
// - parity_err_x  out  1    : present only with NABP_DPRAM_PARITY_EN
// BEHAVIOUR
// - Reset (reset_n low, async):
//   - outputs: data_out_x = 0, valid_x = 0, clear_busy = 0, collision = 0, parity_err_x = 0.
//   - FSM goes to IDLE, sweep counter = 0; RAM contents are not reset.
// - FSM states:
//   - IDLE -> SWEEP on clear.
//   - SWEEP writes 0 to address cnt, cnt++ each cycle.
//   - SWEEP -> IDLE after writing pRAMSize-1, so the sweep takes exactly pRAMSize cycles.
//   - clear_busy is high from the cycle after clear until the IDLE cycle.
// - clear asserted during SWEEP restarts cnt at 0.
// - reset_n low mid-sweep aborts the sweep; contents are partially cleared.
// - During SWEEP:
//   - user writes are dropped;
//   - enabled reads return 0 with valid_x; collision is not flagged.
// - Port access:
//   - en_x high in cycle t gives data_out_x and valid_x at t+pReadLatency.
//   - With en_x low, data_out_x holds its value and valid_x = 0.
//   - Write: en_x & we_x stores data_in_x at addr_x on posedge.
//   - pWriteMode 0: data_out_x returns data_in_x. pWriteMode 1: it returns the old contents.
//   - valid_x also pulses on writes.
// - Cross-port access, same address, same cycle:
//   - read on one port while the other writes returns the old contents (read-first across ports);
//   - both ports writing stores port 0's data and pulses collision in the following cycle.
// - Addresses >= pRAMSize: writes are ignored, reads return 0.
// - Latency 2: the pipeline stalls nothing; the valid pipeline runs every cycle and is flushed only by reset.
// CONFIGURATION
// - NABP_DPRAM_PARITY_EN defined:
//   - each word stores an extra even-parity bit over data_in_x;
//   - the clear sweep writes parity 0;
//   - on read, parity_err_x = recomputed parity ^ stored bit, aligned with data_out_x/valid_x;
//   - parity_err_x = 0 when valid_x = 0.
// - NABP_DPRAM_PARITY_EN undefined: no parity bit, no parity_err_x ports, storage width = pDataLength.
// TESTING (pDataLength=16, pRAMSize=8, pAddrLength=3)
// - reset_n low during traffic -> data_out_x=0, valid_x=0, clear_busy=0 asynchronously.
// - Write 16'hBEEF @3 on port 0, read @3 on port 1 next cycle:
//   - pReadLatency=1: data_out_1=16'hBEEF, valid_1=1 one cycle after enable;
//   - pReadLatency=2: same after two cycles.
// - Preload 16'h1111 @5, then port 0 writes 16'h2222 @5 with en/we high:
//   - pWriteMode 0 -> data_out_0 = 16'h2222;
//   - pWriteMode 1 -> data_out_0 = 16'h1111.
// - Both ports write @2 (16'hAAAA / 16'h5555) -> collision pulses one cycle; later read @2 = 16'hAAAA.
// - Fill all 8 words, pulse clear:
//   - clear_busy high 8 cycles;
//   - a write during the sweep is dropped;
//   - afterwards every address reads 16'h0000;
//   - clear re-pulsed at sweep cycle 4 extends busy to 12 cycles total.
// - Parity build: force a stored bit flip via hierarchical poke @1, read @1 -> parity_err_0=1 with valid_0.

Source files
------------

// File: rtl/nabp_param_dual_port_ram.sv
// True dual-port RAM with sequential clear sweep, per-port valid pipeline (latency 1 or 2),
// selectable same-port read-during-write and write-collision flag; NABP_DPRAM_PARITY_EN adds even parity.
`ifndef kFilteredDataLength
`define kFilteredDataLength 16
`endif
`ifndef kProjectionLineSize
`define kProjectionLineSize 8
`endif
`ifndef kSLength
`define kSLength 3
`endif

module nabp_param_dual_port_ram #(
  parameter int pDataLength  = `kFilteredDataLength,
  parameter int pRAMSize     = `kProjectionLineSize,
  parameter int pAddrLength  = `kSLength,
  parameter int pReadLatency = 1,
  parameter int pWriteMode   = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  output logic                   clear_busy,
  output logic                   collision,
  input  logic                   en_0,
  input  logic                   we_0,
  input  logic [pAddrLength-1:0] addr_0,
  input  logic [pDataLength-1:0] data_in_0,
  output logic [pDataLength-1:0] data_out_0,
  output logic                   valid_0,
`ifdef NABP_DPRAM_PARITY_EN
  output logic                   parity_err_0,
  output logic                   parity_err_1,
`endif
  input  logic                   en_1,
  input  logic                   we_1,
  input  logic [pAddrLength-1:0] addr_1,
  input  logic [pDataLength-1:0] data_in_1,
  output logic [pDataLength-1:0] data_out_1,
  output logic                   valid_1
);

`ifdef NABP_DPRAM_PARITY_EN
  localparam int kParW = 1;
`else
  localparam int kParW = 0;
`endif
  localparam int kWordW = pDataLength + kParW;
  localparam logic [pAddrLength:0]   kSize = (pAddrLength+1)'(pRAMSize);
  localparam logic [pAddrLength-1:0] kLast = pAddrLength'(pRAMSize - 1);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e                 state_q, state_d;
  logic [pAddrLength-1:0] cnt_q, cnt_d;
  logic                   sweep;

  logic                   en [2];
  logic                   we [2];
  logic [pAddrLength-1:0] addr [2];
  logic [pDataLength-1:0] din [2];
  logic [kWordW-1:0]      wr_word [2];
  logic [kWordW-1:0]      rd_word [2];
  logic                   wr_ok [2];
  logic [kWordW-1:0]      mem_q [pRAMSize];

  logic [pDataLength-1:0] s1_dat_q [2];
  logic                   s1_vld_q [2];
  logic [pDataLength-1:0] out_dat [2];
  logic                   out_vld [2];
  logic                   collision_q, collision_d;

  assign en[0]   = en_0;
  assign en[1]   = en_1;
  assign we[0]   = we_0;
  assign we[1]   = we_1;
  assign addr[0] = addr_0;
  assign addr[1] = addr_1;
  assign din[0]  = data_in_0;
  assign din[1]  = data_in_1;

  function automatic logic [kWordW-1:0] encode(input logic [pDataLength-1:0] d);
`ifdef NABP_DPRAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == kLast) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sweep      = (state_q == SWEEP);
    clear_busy = sweep;
  end

  // Memory is read before the write lands, so cross-port reads see old contents.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wr_word[p] = encode(din[p]);
      wr_ok[p]   = 1'b0;
      rd_word[p] = '0;
      if (!sweep && ({1'b0, addr[p]} < kSize)) begin
        wr_ok[p]   = en[p] & we[p];
        rd_word[p] = (wr_ok[p] && pWriteMode == 0) ? wr_word[p] : mem_q[addr[p]];
      end
    end
    collision_d = wr_ok[0] & wr_ok[1] & (addr[0] == addr[1]);
  end

  // Port 0 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (sweep) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (wr_ok[1]) mem_q[addr[1]] <= wr_word[1];
      if (wr_ok[0]) mem_q[addr[0]] <= wr_word[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collision_q <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        s1_dat_q[p] <= '0;
        s1_vld_q[p] <= 1'b0;
      end
    end else begin
      collision_q <= collision_d;
      for (int p = 0; p < 2; p++) begin
        s1_vld_q[p] <= en[p];
        if (en[p]) s1_dat_q[p] <= rd_word[p][pDataLength-1:0];
      end
    end
  end

`ifdef NABP_DPRAM_PARITY_EN
  logic s1_err_q [2];
  logic out_err [2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) s1_err_q[p] <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) s1_err_q[p] <= en[p] & (^rd_word[p]);
    end
  end
`endif

  if (pReadLatency == 2) begin : g_lat2
    logic [pDataLength-1:0] s2_dat_q [2];
    logic                   s2_vld_q [2];
`ifdef NABP_DPRAM_PARITY_EN
    logic                   s2_err_q [2];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int p = 0; p < 2; p++) begin
          s2_dat_q[p] <= '0;
          s2_vld_q[p] <= 1'b0;
`ifdef NABP_DPRAM_PARITY_EN
          s2_err_q[p] <= 1'b0;
`endif
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          s2_vld_q[p] <= s1_vld_q[p];
          if (s1_vld_q[p]) s2_dat_q[p] <= s1_dat_q[p];
`ifdef NABP_DPRAM_PARITY_EN
          s2_err_q[p] <= s1_err_q[p];
`endif
        end
      end
    end

    always_comb begin
      for (int p = 0; p < 2; p++) begin
        out_dat[p] = s2_dat_q[p];
        out_vld[p] = s2_vld_q[p];
`ifdef NABP_DPRAM_PARITY_EN
        out_err[p] = s2_err_q[p];
`endif
      end
    end
  end else begin : g_lat1
    always_comb begin
      for (int p = 0; p < 2; p++) begin
        out_dat[p] = s1_dat_q[p];
        out_vld[p] = s1_vld_q[p];
`ifdef NABP_DPRAM_PARITY_EN
        out_err[p] = s1_err_q[p];
`endif
      end
    end
  end

  assign data_out_0 = out_dat[0];
  assign data_out_1 = out_dat[1];
  assign valid_0    = out_vld[0];
  assign valid_1    = out_vld[1];
  assign collision  = collision_q;
`ifdef NABP_DPRAM_PARITY_EN
  assign parity_err_0 = out_err[0];
  assign parity_err_1 = out_err[1];
`endif

endmodule

// File: tb/tb_nabp_param_dual_port_ram.sv
// Scoreboard bench for nabp_param_dual_port_ram (16-bit words, 8 entries).
module tb_nabp_param_dual_port_ram #(
  parameter int RL = 1,
  parameter int WM = 0
);
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        clear = 1'b0;
  logic        clear_busy, collision;
  logic        en_0 = 1'b0, we_0 = 1'b0, en_1 = 1'b0, we_1 = 1'b0;
  logic [2:0]  addr_0 = '0, addr_1 = '0;
  logic [15:0] data_in_0 = '0, data_in_1 = '0;
  logic [15:0] data_out_0, data_out_1;
  logic        valid_0, valid_1;
`ifdef NABP_DPRAM_PARITY_EN
  logic        parity_err_0, parity_err_1;
`endif

  nabp_param_dual_port_ram #(
    .pDataLength(16), .pRAMSize(8), .pAddrLength(3),
    .pReadLatency(RL), .pWriteMode(WM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .clear_busy(clear_busy), .collision(collision),
    .en_0(en_0), .we_0(we_0), .addr_0(addr_0), .data_in_0(data_in_0),
    .data_out_0(data_out_0), .valid_0(valid_0),
`ifdef NABP_DPRAM_PARITY_EN
    .parity_err_0(parity_err_0), .parity_err_1(parity_err_1),
`endif
    .en_1(en_1), .we_1(we_1), .addr_1(addr_1), .data_in_1(data_in_1),
    .data_out_1(data_out_1), .valid_1(valid_1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          cyc;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b1;
  logic [15:0] mdl [8];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Stage one access for this cycle and record the response it must produce.
  task automatic acc(input int p, input logic w, input logic [2:0] a, input logic [15:0] d,
                     input logic [15:0] e, input logic pe);
    exp_t x;
    x.d = e;
    x.cyc = cyc + RL;
    x.err = pe;
    if (p == 0) begin
      en_0 = 1'b1; we_0 = w; addr_0 = a; data_in_0 = d; q0.push_back(x);
    end else begin
      en_1 = 1'b1; we_1 = w; addr_1 = a; data_in_1 = d; q1.push_back(x);
    end
  endtask

  task automatic step();
    @(negedge clk);
    en_0 = 1'b0; we_0 = 1'b0; en_1 = 1'b0; we_1 = 1'b0;
  endtask

  task automatic drain();
    repeat (RL + 2) step();
  endtask

  task automatic do_clear(input int restart_k, input int drop_k, input int exp_n, input string nm);
    int n;
    n = 0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 40 && clear_busy; k++) begin
      if (k == restart_k) clear = 1'b1;
      if (k == drop_k) acc(1, 1'b1, 3'd6, 16'h7777, 16'h0000, 1'b0);
      n++;
      step();
      clear = 1'b0;
    end
    chk(nm, 32'(n), 32'(exp_n));
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n) begin
        if (valid_0) begin
          if (q0.size() == 0) chk("p0_unexpected_valid", 32'd1, 32'd0);
          else begin
            x = q0.pop_front();
            chk("p0_data", 32'(data_out_0), 32'(x.d));
            chk("p0_latency", 32'(cyc), 32'(x.cyc));
`ifdef NABP_DPRAM_PARITY_EN
            chk("p0_parity_err", 32'(parity_err_0), 32'(x.err));
`endif
          end
        end
        if (valid_1) begin
          if (q1.size() == 0) chk("p1_unexpected_valid", 32'd1, 32'd0);
          else begin
            x = q1.pop_front();
            chk("p1_data", 32'(data_out_1), 32'(x.d));
            chk("p1_latency", 32'(cyc), 32'(x.cyc));
`ifdef NABP_DPRAM_PARITY_EN
            chk("p1_parity_err", 32'(parity_err_1), 32'(x.err));
`endif
          end
        end
      end
    end
  end

  initial begin : stim
    #3 reset_n = 1'b0;
    #1;
    chk("rst_data_out_0", 32'(data_out_0), 32'h0);
    chk("rst_data_out_1", 32'(data_out_1), 32'h0);
    chk("rst_valid", 32'({valid_0, valid_1}), 32'h0);
    chk("rst_busy_coll", 32'({clear_busy, collision}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    do_clear(-1, -1, 8, "init_busy_len");
    drain();

    acc(0, 1'b1, 3'd3, 16'hBEEF, (WM != 0) ? 16'h0000 : 16'hBEEF, 1'b0);
    step();
    acc(1, 1'b0, 3'd3, 16'h0000, 16'hBEEF, 1'b0);
    step();

    acc(1, 1'b1, 3'd5, 16'h1111, (WM != 0) ? 16'h0000 : 16'h1111, 1'b0);
    step();
    acc(0, 1'b1, 3'd5, 16'h2222, (WM != 0) ? 16'h1111 : 16'h2222, 1'b0);
    step();
    acc(0, 1'b0, 3'd5, 16'h0000, 16'h2222, 1'b0);
    step();
    // Cross-port: port 1 reads while port 0 overwrites the same word.
    acc(0, 1'b1, 3'd5, 16'h3333, (WM != 0) ? 16'h2222 : 16'h3333, 1'b0);
    acc(1, 1'b0, 3'd5, 16'h0000, 16'h2222, 1'b0);
    step();
    acc(0, 1'b0, 3'd5, 16'h0000, 16'h3333, 1'b0);
    step();

    acc(0, 1'b1, 3'd2, 16'hAAAA, (WM != 0) ? 16'h0000 : 16'hAAAA, 1'b0);
    acc(1, 1'b1, 3'd2, 16'h5555, (WM != 0) ? 16'h0000 : 16'h5555, 1'b0);
    chk("collision_before", 32'(collision), 32'h0);
    step();
    chk("collision_pulse", 32'(collision), 32'h1);
    step();
    chk("collision_clears", 32'(collision), 32'h0);
    acc(1, 1'b0, 3'd2, 16'h0000, 16'hAAAA, 1'b0);
    step();
    drain();
    chk("hold_data_out_1", 32'(data_out_1), 32'hAAAA);
    chk("hold_valid_1", 32'(valid_1), 32'h0);

    mdl[0] = 16'h0000; mdl[1] = 16'h0000; mdl[2] = 16'hAAAA; mdl[3] = 16'hBEEF;
    mdl[4] = 16'h0000; mdl[5] = 16'h3333; mdl[6] = 16'h0000; mdl[7] = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      acc(0, 1'b1, 3'(i), 16'hC0D0 + 16'(i), (WM != 0) ? mdl[i] : 16'hC0D0 + 16'(i), 1'b0);
      step();
    end
    drain();

    do_clear(-1, 2, 8, "clear_busy_len");
    drain();
    for (int i = 0; i < 8; i++) begin
      acc(i % 2, 1'b0, 3'(i), 16'h0000, 16'h0000, 1'b0);
      step();
    end
    drain();

    do_clear(3, -1, 12, "restart_busy_len");
    drain();

`ifdef NABP_DPRAM_PARITY_EN
    acc(0, 1'b1, 3'd1, 16'h1234, (WM != 0) ? 16'h0000 : 16'h1234, 1'b0);
    step();
    drain();
    dut.mem_q[1][16] = ~dut.mem_q[1][16];
    acc(0, 1'b0, 3'd1, 16'h0000, 16'h1234, 1'b1);
    step();
    drain();
`endif

    acc(0, 1'b1, 3'd4, 16'h4444, (WM != 0) ? 16'h0000 : 16'h4444, 1'b0);
    step();
    drain();
    mon_en = 1'b0;
    en_0 = 1'b1; we_0 = 1'b0; addr_0 = 3'd4;
    @(negedge clk);
    en_0 = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("pre_reset_busy", 32'(clear_busy), 32'h1);
    chk("pre_reset_data", 32'(data_out_0), 32'h4444);
    reset_n = 1'b0;
    #1;
    chk("async_rst_data_out_0", 32'(data_out_0), 32'h0);
    chk("async_rst_valid", 32'({valid_0, valid_1}), 32'h0);
    chk("async_rst_busy", 32'(clear_busy), 32'h0);
    chk("async_rst_collision", 32'(collision), 32'h0);

    chk("q0_empty", 32'(q0.size()), 32'h0);
    chk("q1_empty", 32'(q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
